// File: rtl/fsm_fifo_mc_if.sv
// Command/status bundle for the multi-channel FIFO: the sequencer drives the
// command side (master), the FIFO block answers with status (slave).
interface fsm_fifo_mc_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CH_W     = 1
);
  logic                             start;
  logic                             write;
  logic [CH_W-1:0]                  ch;
  logic [WIDTH-1:0]                 data_in;
  logic                             clr_err;
  logic [WIDTH-1:0]                 data_out;
  logic                             done;
  logic                             err;
  logic                             busy;
  logic [CHANNELS-1:0]              full;
  logic [CHANNELS-1:0]              empty;
  logic [CHANNELS-1:0]              almost_full;
  logic [CHANNELS-1:0]              almost_empty;
  logic [CHANNELS*(ADDR_W+1)-1:0]   count;
  logic [CHANNELS-1:0]              ovf;
  logic [CHANNELS-1:0]              udf;

  modport master (
    output start, write, ch, data_in, clr_err,
    input  data_out, done, err, busy, full, empty, almost_full, almost_empty, count, ovf, udf
  );

  modport slave (
    input  start, write, ch, data_in, clr_err,
    output data_out, done, err, busy, full, empty, almost_full, almost_empty, count, ovf, udf
  );
endinterface

// File: rtl/fsm_fifo_mc.sv
// Multi-channel FIFO behind a single start/write/done command port. All
// channels share one storage array; channel n owns words [n*DEPTH, n*DEPTH+DEPTH).
// A command takes three cycles: capture (IDLE), operate (EXEC), report (DONE),
// with done/err registered so they appear on the cycle after leaving DONE.
module fsm_fifo_mc #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned CH_W      = 1,
  parameter int unsigned AF_THRESH = 28,
  parameter int unsigned AE_THRESH = 4
) (
  input logic          clk,
  input logic          ClearAllReg,
  fsm_fifo_mc_if.slave bus
);

  localparam int unsigned CntW  = ADDR_W + 1;
  localparam int unsigned MemW  = CH_W + ADDR_W;
  localparam int unsigned NumCh = 1 << CH_W;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e state_q, state_d;

  logic              cmd_write_q;
  logic [CH_W-1:0]   cmd_ch_q;
  logic [WIDTH-1:0]  cmd_data_q;

  logic [ADDR_W-1:0] wptr_q [CHANNELS];
  logic [ADDR_W-1:0] wptr_d [CHANNELS];
  logic [ADDR_W-1:0] rptr_q [CHANNELS];
  logic [ADDR_W-1:0] rptr_d [CHANNELS];
  logic [CntW-1:0]   cnt_q  [CHANNELS];
  logic [CntW-1:0]   cnt_d  [CHANNELS];

  logic [CHANNELS-1:0] ovf_q, ovf_d, udf_q, udf_d;
  logic                exec_err_q, exec_err_d;
  logic                done_q, err_q;
  logic [WIDTH-1:0]    data_out_q;

  // Storage is deliberately not reset.
  logic [WIDTH-1:0] mem [CHANNELS*DEPTH];

  logic [NumCh-1:0] ch_legal;
  logic             sel_legal;
  logic [CntW-1:0]  sel_cnt;
  logic             exec;
  logic             push_ok, pop_ok;
  logic [MemW-1:0]  wr_addr, rd_addr;

  // Channel codes at or above CHANNELS are rejected without touching state.
  always_comb begin
    ch_legal = '0;
    for (int unsigned i = 0; i < NumCh; i++) begin
      ch_legal[i] = (i < CHANNELS);
    end
  end

  // Decode the captured command against the selected channel's occupancy.
  always_comb begin
    exec      = (state_q == StExec);
    sel_legal = ch_legal[cmd_ch_q];
    sel_cnt   = cnt_q[cmd_ch_q];
    push_ok   = exec && sel_legal && cmd_write_q && (sel_cnt != CntW'(DEPTH));
    pop_ok    = exec && sel_legal && !cmd_write_q && (sel_cnt != '0);
    // DEPTH is a power of two, so base(ch) + ptr is a plain concatenation.
    wr_addr   = {cmd_ch_q, wptr_q[cmd_ch_q]};
    rd_addr   = {cmd_ch_q, rptr_q[cmd_ch_q]};
  end

  // Next-state: FSM sequencing, pointer/count updates and sticky error flags.
  always_comb begin
    state_d    = state_q;
    exec_err_d = exec_err_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    ovf_d      = bus.clr_err ? '0 : ovf_q;
    udf_d      = bus.clr_err ? '0 : udf_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = StExec;
      end
      StExec: begin
        state_d    = StDone;
        exec_err_d = !(push_ok || pop_ok);
        if (push_ok) begin
          wptr_d[cmd_ch_q] = wptr_q[cmd_ch_q] + ADDR_W'(1);
          cnt_d[cmd_ch_q]  = cnt_q[cmd_ch_q] + CntW'(1);
        end
        if (pop_ok) begin
          rptr_d[cmd_ch_q] = rptr_q[cmd_ch_q] + ADDR_W'(1);
          cnt_d[cmd_ch_q]  = cnt_q[cmd_ch_q] - CntW'(1);
        end
        // Setting a flag takes priority over a simultaneous clr_err.
        if (sel_legal && cmd_write_q && !push_ok) ovf_d[cmd_ch_q] = 1'b1;
        if (sel_legal && !cmd_write_q && !pop_ok) udf_d[cmd_ch_q] = 1'b1;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset aborts any in-flight command with no partial update.
  always_ff @(posedge clk or negedge ClearAllReg) begin
    if (!ClearAllReg) begin
      state_q     <= StIdle;
      cmd_write_q <= 1'b0;
      cmd_ch_q    <= '0;
      cmd_data_q  <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      ovf_q      <= '0;
      udf_q      <= '0;
      exec_err_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      exec_err_q <= exec_err_d;
      done_q     <= (state_q == StDone);
      err_q      <= (state_q == StDone) && exec_err_q;
      if (state_q == StIdle && bus.start) begin
        cmd_write_q <= bus.write;
        cmd_ch_q    <= bus.ch;
        cmd_data_q  <= bus.data_in;
      end
      if (pop_ok) data_out_q <= mem[rd_addr];
    end
  end

  // Shared storage: synchronous write on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_addr] <= cmd_data_q;
  end

  // Outputs: registered pulses plus combinational decodes of the counts.
  always_comb begin
    bus.data_out     = data_out_q;
    bus.done         = done_q;
    bus.err          = err_q;
    bus.busy         = (state_q != StIdle);
    bus.ovf          = ovf_q;
    bus.udf          = udf_q;
    bus.full         = '0;
    bus.empty        = '0;
    bus.almost_full  = '0;
    bus.almost_empty = '0;
    bus.count        = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      bus.full[i]                 = (cnt_q[i] == CntW'(DEPTH));
      bus.empty[i]                = (cnt_q[i] == '0);
      bus.almost_full[i]          = (cnt_q[i] >= CntW'(AF_THRESH));
      bus.almost_empty[i]         = (cnt_q[i] <= CntW'(AE_THRESH));
      bus.count[i*CntW +: CntW]   = cnt_q[i];
    end
  end

endmodule
